// File: rtl/pipeline_hazard_controller.sv
// Pipeline register sequencer: load-use stall, EX branch flush and data-memory wait freeze with timeout.
// Optional PIPE_PERF_CNT_EN adds stall/flush event counters.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_IFID_in,
  input  logic [31:0] instruction_IDEX_in,
  input  logic        MemRead_IDEX_in,
  input  logic        branch_taken_EX,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_bubble,
  output logic        mem_timeout_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            err_nxt;

  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic       lu;
  logic       mem_done;

  assign rd_ex  = instruction_IDEX_in[11:7];
  assign rs1_id = instruction_IFID_in[19:15];
  assign rs2_id = instruction_IFID_in[24:20];

  // rs2 compared regardless of format; an occasional spurious stall is harmless
  assign lu = MemRead_IDEX_in && (rd_ex != 5'd0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
  assign mem_done = dmem_req && dmem_ack;

  logic unused_bits;
  assign unused_bits = ^{instruction_IFID_in[31:25], instruction_IFID_in[14:0],
                         instruction_IDEX_in[31:12], instruction_IDEX_in[6:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      cnt             <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      mem_timeout_err <= err_nxt;
    end
  end

  // Next state and pipeline controls; reset forces the free-running defaults
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    err_nxt      = mem_timeout_err;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ack) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            cnt_nxt      = TO_W'(1);
            state_nxt    = MEM_WAIT;
          end else if (branch_taken_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else if (cnt == TO_W'(MEM_TIMEOUT)) begin
            // abandoned access: pipeline moves on but the MEM/WB write is suppressed
            memwb_bubble = 1'b1;
            err_nxt      = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = RUN;
          end else begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            cnt_nxt      = cnt + TO_W'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en)     stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (MEM_TIMEOUT=4).
module tb_pipeline_hazard_controller;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned TO_W        = 8;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
  localparam logic [6:0] DEF = 7'b1101010;
  localparam logic [6:0] LUS = 7'b0001110;
  localparam logic [6:0] BRF = 7'b1111110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] TOR = 7'b1101011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_IFID_in, instruction_IDEX_in;
  logic        MemRead_IDEX_in, branch_taken_EX, dmem_req, dmem_ack;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
  logic        mem_timeout_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instruction_IFID_in (instruction_IFID_in),
    .instruction_IDEX_in (instruction_IDEX_in),
    .MemRead_IDEX_in     (MemRead_IDEX_in),
    .branch_taken_EX     (branch_taken_EX),
    .dmem_req            (dmem_req),
    .dmem_ack            (dmem_ack),
    .pc_en               (pc_en),
    .ifid_en             (ifid_en),
    .ifid_flush          (ifid_flush),
    .idex_en             (idex_en),
    .idex_flush          (idex_flush),
    .exmem_en            (exmem_en),
    .memwb_bubble        (memwb_bubble),
    .mem_timeout_err     (mem_timeout_err)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles        (stall_cycles),
    .flush_events        (flush_events)
`endif
  );

  logic [6:0] outs;
  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};

  typedef struct {
    string      nm;
    logic [4:0] rd, rs1, rs2;
    logic       mr, br, req, ack;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic mr, input logic br, input logic req, input logic ack);
    instruction_IDEX_in = mk(rd, 5'd0, 5'd0);
    instruction_IFID_in = mk(5'd6, rs1, rs2);
    MemRead_IDEX_in     = mr;
    branch_taken_EX     = br;
    dmem_req            = req;
    dmem_ack            = ack;
  endtask

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Leaves reset low right after a negedge, state already reset
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic mr, input logic br, input logic req, input logic ack);
    @(negedge clk);
    drive(rd, rs1, rs2, mr, br, req, ack);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"idle",          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
    vecs[1]  = '{"lu_rs1",        5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LUS};
    vecs[2]  = '{"lu_rs2",        5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LUS};
    vecs[3]  = '{"lu_rd0",        5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF};
    vecs[4]  = '{"lu_nomemread",  5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, DEF};
    vecs[5]  = '{"lu_nomatch",    5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, DEF};
    vecs[6]  = '{"branch_over_lu",5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, BRF};
    vecs[7]  = '{"branch",        5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, BRF};
    vecs[8]  = '{"mem_1cyc_lu",   5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, LUS};
    vecs[9]  = '{"ack_noreq",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF};
    vecs[10] = '{"freeze_beats",  5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, FRZ};

    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("in_reset_outs", outs, DEF);
    chk1("in_reset_err", mem_timeout_err, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_reset_outs", outs, DEF);

    // Single-cycle vectors, each from a fresh RUN state
    for (int i = 0; i < 11; i++) begin
      do_reset();
      drive(vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].mr, vecs[i].br, vecs[i].req, vecs[i].ack);
      #1;
      chk(vecs[i].nm, outs, vecs[i].exp);
    end

    // Load-use stall lasts one cycle: the load moves on and a bubble sits in EX
    do_reset();
    step(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_seq_stall", outs, LUS);
    step(5'd0, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_seq_release", outs, DEF);

    // Memory ack on the 4th cycle of the request: three freeze cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("mem_wait_frz%0d", i), outs, FRZ);
    end
    step(5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("mem_wait_ack_release", outs, DEF);
    step(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mem_wait_back_run", outs, LUS);
    chk1("mem_wait_no_err", mem_timeout_err, 1'b0);

    // Timeout: MEM_TIMEOUT freeze cycles, then release with bubble and sticky err
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("to_frz%0d", i), outs, FRZ);
    end
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("to_release", outs, TOR);
    chk1("to_err_not_yet", mem_timeout_err, 1'b0);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_after_run", outs, DEF);
    chk1("to_err_set", mem_timeout_err, 1'b1);
    step(5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("to_run_branch", outs, BRF);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("to_err_sticky", mem_timeout_err, 1'b1);

    // Reset during the 2nd MEM_WAIT cycle clears err and state
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_seq_entry", outs, FRZ);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_seq_wait1", outs, FRZ);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_seq_during", outs, DEF);
    chk1("rst_seq_err_before", mem_timeout_err, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_seq_after", outs, DEF);
    chk1("rst_seq_err_clr", mem_timeout_err, 1'b0);

`ifdef PIPE_PERF_CNT_EN
    do_reset();
    step(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (stall_cycles === 32'd1) passed++;
    else $display("FAIL perf_stall: got %0d expected 1", stall_cycles);
    total++;
    if (flush_events === 32'd1) passed++;
    else $display("FAIL perf_flush: got %0d expected 1", flush_events);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
